lfsr_rr_scheduler: RTL and testbench
====================================

// Module: lfsr_rr_scheduler
// PURPOSE
//  Shares one Fibonacci LFSR (shift-left, feedback into bit 0) among NREQ requesters.
//  A round-robin arbiter picks one requester, advances the LFSR STEPS times, then
//  returns the fresh value with a one-cycle grant. Sits between the pseudo-random
//  source and its consumers (LED patterns, test stimulus, backoff timers).
// PARAMETERS
//  WIDTH     4        LFSR width in bits (>=2)
//  TAP_MASK  4'b1100  feedback = ^(lfsr & TAP_MASK); default = q[3]^q[2]
//  SEED      4'b0001  reset value, and substitute for any zero seed (must be nonzero)
//  NREQ      2        number of requesters (>=1)
//  STEPS     1        LFSR advances per grant (1..15)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-low reset
//  req        in   NREQ   level request per requester; hold until granted
//  seed_load  in   1      load seed_val (priority over all activity)
//  seed_val   in   WIDTH  seed to load; zero is replaced by SEED
//  gnt        out  NREQ   one-hot grant, 1 cycle, registered
//  rnd_valid  out  1      rnd_data valid; high exactly when gnt != 0
//  rnd_data   out  WIDTH  LFSR value delivered with the grant
//  busy       out  1      high in STEP or GRANT
//  wrap       out  1      1-cycle pulse: an advance produced the last-loaded seed
// BEHAVIOUR
//  Reset (rst=0): lfsr=SEED, cur_seed=SEED, state=IDLE, rr_ptr=0, step_cnt=0,
//   target=0, gnt=0, rnd_valid=0, rnd_data=0, busy=0, wrap=0.
//  Advance: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAP_MASK)}. Only in STEP.
//  FSM:
//   IDLE:  if |req: target = first set req at or after rr_ptr (wrap NREQ-1 -> 0),
//          step_cnt=0, go STEP. Otherwise stay IDLE.
//   STEP:  advance each cycle, step_cnt++. After STEPS advances, go GRANT.
//   GRANT: if req[target]=1: gnt=onehot(target), rnd_valid=1, rnd_data=lfsr,
//          rr_ptr=(target+1)%NREQ. If req[target]=0: cancelled; gnt=0,
//          rnd_valid=0, rr_ptr unchanged, LFSR steps kept. Next state IDLE.
//  Latency: req sampled in IDLE at edge N -> gnt/rnd_valid high in cycle N+STEPS+1,
//   for exactly one cycle. rnd_data holds the last delivered value between grants.
//  Back-to-back: min spacing between grants = STEPS+2 cycles.
//  Fairness: a held request is granted within NREQ arbitration rounds.
//  wrap: asserted in the cycle after an advance whose result == cur_seed.
//  seed_load=1 (any state, synchronous):
//   lfsr = cur_seed = (seed_val==0 ? SEED : seed_val), state=IDLE, step_cnt=0.
//   An in-flight STEP/GRANT is aborted: no grant, rr_ptr unchanged.
//   Wins over a same-cycle grant; gnt/rnd_valid/wrap forced 0 that cycle.
//  Zero lockup: if lfsr==0 is ever seen, the next update loads SEED instead of advancing.
//  Reset asserted mid-operation: all state returns to reset values immediately.
// TESTING
//  1) Reset, STEPS=1, req=01 -> gnt=01, rnd_data=4'b0010, 2 cycles after req sampled.
//  2) req=11 held -> grants alternate 01,10,01 with data 0010,0100,1001;
//     spacing 3 cycles.
//  3) Continuous req=01, 15 grants -> data sequence
//     0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001;
//     wrap pulses after the 15th advance.
//  4) seed_load with seed_val=0 during STEP -> no grant, lfsr=0001; next grant data=0010.
//  5) req[0] dropped during STEP -> no gnt in GRANT, rr_ptr unchanged;
//     re-request delivers the next LFSR value.
//  6) rst low mid-STEP (async, between edges) -> all outputs 0 at once;
//     after release, lfsr=0001.

Source files
------------

// File: rtl/lfsr_rr_scheduler_if.sv
// Request/grant bundle between the shared LFSR scheduler and its consumers.
// Consumers drive requests and seed loads; the scheduler answers with grants and data.
interface lfsr_rr_scheduler_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
);

  logic [NREQ-1:0]  req;
  logic             seed_load;
  logic [WIDTH-1:0] seed_val;
  logic [NREQ-1:0]  gnt;
  logic             rnd_valid;
  logic [WIDTH-1:0] rnd_data;
  logic             busy;
  logic             wrap;

  modport master (
    output req,
    output seed_load,
    output seed_val,
    input  gnt,
    input  rnd_valid,
    input  rnd_data,
    input  busy,
    input  wrap
  );

  modport slave (
    input  req,
    input  seed_load,
    input  seed_val,
    output gnt,
    output rnd_valid,
    output rnd_data,
    output busy,
    output wrap
  );

endinterface

// File: rtl/lfsr_rr_scheduler.sv
// One Fibonacci LFSR shared round-robin among NREQ requesters: pick a requester,
// advance the LFSR STEPS times, then hand the fresh value over with a one-cycle grant.
module lfsr_rr_scheduler #(
  parameter int             WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAP_MASK = 4'b1100,
  parameter logic [WIDTH-1:0] SEED     = 4'b0001,
  parameter int             NREQ     = 2,
  parameter int             STEPS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  lfsr_rr_scheduler_if.slave    bus
);

  localparam int         PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t           state,     state_nxt;
  logic [WIDTH-1:0] lfsr,      lfsr_nxt;
  logic [WIDTH-1:0] cur_seed,  cur_seed_nxt;
  logic [PW-1:0]    rr_ptr,    rr_ptr_nxt;
  logic [PW-1:0]    target,    target_nxt;
  logic [3:0]       step_cnt,  step_cnt_nxt;
  logic [NREQ-1:0]  gnt,       gnt_nxt;
  logic             rnd_valid, rnd_valid_nxt;
  logic [WIDTH-1:0] rnd_data,  rnd_data_nxt;
  logic             wrap,      wrap_nxt;

  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] loaded_seed;

  // First requester at or after ptr, scanning upward and wrapping to 0.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   ptr);
    logic [PW-1:0] sel;
    logic          found;
    int            idx;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && r[idx]) begin
        sel   = PW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // A zero register would lock up the shift sequence, so it restarts from SEED.
  assign stepped     = (lfsr == '0) ? SEED
                                    : {lfsr[WIDTH-2:0], ^(lfsr & TAP_MASK)};
  assign loaded_seed = (bus.seed_val == '0) ? SEED : bus.seed_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lfsr      <= SEED;
      cur_seed  <= SEED;
      rr_ptr    <= '0;
      target    <= '0;
      step_cnt  <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      cur_seed  <= cur_seed_nxt;
      rr_ptr    <= rr_ptr_nxt;
      target    <= target_nxt;
      step_cnt  <= step_cnt_nxt;
      gnt       <= gnt_nxt;
      rnd_valid <= rnd_valid_nxt;
      rnd_data  <= rnd_data_nxt;
      wrap      <= wrap_nxt;
    end
  end

  // Seed load aborts whatever is in flight and suppresses that cycle's grant and wrap.
  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    cur_seed_nxt  = cur_seed;
    rr_ptr_nxt    = rr_ptr;
    target_nxt    = target;
    step_cnt_nxt  = step_cnt;
    gnt_nxt       = '0;
    rnd_valid_nxt = 1'b0;
    rnd_data_nxt  = rnd_data;
    wrap_nxt      = 1'b0;

    if (bus.seed_load) begin
      lfsr_nxt     = loaded_seed;
      cur_seed_nxt = loaded_seed;
      step_cnt_nxt = '0;
      state_nxt    = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            target_nxt   = rr_pick(bus.req, rr_ptr);
            step_cnt_nxt = '0;
            state_nxt    = STEP;
          end
        end
        STEP: begin
          lfsr_nxt     = stepped;
          wrap_nxt     = (stepped == cur_seed);
          step_cnt_nxt = step_cnt + 4'd1;
          if (step_cnt == LAST_STEP) begin
            state_nxt = GRANT;
          end
        end
        GRANT: begin
          // A dropped request cancels the grant but keeps the LFSR progress.
          if (bus.req[target]) begin
            gnt_nxt       = NREQ'(1) << target;
            rnd_valid_nxt = 1'b1;
            rnd_data_nxt  = lfsr;
            rr_ptr_nxt    = (int'(target) == NREQ - 1) ? '0 : target + PW'(1);
          end
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.rnd_valid = rnd_valid;
  assign bus.rnd_data  = rnd_data;
  assign bus.busy      = (state != IDLE);
  assign bus.wrap      = wrap;

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// Directed bench for lfsr_rr_scheduler at default parameters (WIDTH=4, NREQ=2, STEPS=1);
// expected values are the hand-derived LFSR sequence from seed 0001 with taps q[3]^q[2].
module tb_lfsr_rr_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  lfsr_rr_scheduler_if #(.WIDTH(4), .NREQ(2)) bus ();

  lfsr_rr_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic sl, input logic [3:0] sv);
    bus.req       = r;
    bus.seed_load = sl;
    bus.seed_val  = sv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0, 4'h0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [3:0] seq [15];
  logic [1:0] exp_gnt [3];

  initial begin
    checks   = 0;
    failures = 0;
    seq = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
            4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    exp_gnt = '{2'b01, 2'b10, 2'b01};

    // Reset values
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0, 4'h0);
    tick();
    checkOutput("rst_gnt",   32'(bus.gnt),       0);
    checkOutput("rst_valid", 32'(bus.rnd_valid), 0);
    checkOutput("rst_data",  32'(bus.rnd_data),  0);
    checkOutput("rst_busy",  32'(bus.busy),      0);
    checkOutput("rst_wrap",  32'(bus.wrap),      0);
    rst = 1'b1;

    // Single request, two-cycle latency
    applyStimulus(2'b01, 1'b0, 4'h0);
    tick();
    checkOutput("t1_busy_step", 32'(bus.busy), 1);
    checkOutput("t1_gnt_step",  32'(bus.gnt),  0);
    tick();
    checkOutput("t1_gnt_early", 32'(bus.gnt),  0);
    checkOutput("t1_wrap",      32'(bus.wrap), 0);
    tick();
    checkOutput("t1_gnt",   32'(bus.gnt),       'h1);
    checkOutput("t1_valid", 32'(bus.rnd_valid), 1);
    checkOutput("t1_data",  32'(bus.rnd_data),  'h2);
    checkOutput("t1_busy",  32'(bus.busy),      0);
    applyStimulus(2'b00, 1'b0, 4'h0);
    tick();
    checkOutput("t1_gnt_once", 32'(bus.gnt),       0);
    checkOutput("t1_valid_off", 32'(bus.rnd_valid), 0);
    checkOutput("t1_data_hold", 32'(bus.rnd_data),  'h2);

    // Both requesters held: alternate grants every 3 cycles
    applyReset();
    applyStimulus(2'b11, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t2_gap_gnt", 32'(bus.gnt), 0);
      tick();
      tick();
      checkOutput("t2_gnt",   32'(bus.gnt),      32'(exp_gnt[i]));
      checkOutput("t2_data",  32'(bus.rnd_data), 32'(seq[i]));
    end
    applyStimulus(2'b00, 1'b0, 4'h0);

    // Full period: 15 grants, wrap after the 15th advance
    applyReset();
    applyStimulus(2'b01, 1'b0, 4'h0);
    for (int k = 0; k < 15; k++) begin
      tick();
      checkOutput("t3_gap_gnt", 32'(bus.gnt), 0);
      tick();
      checkOutput("t3_wrap", 32'(bus.wrap), (k == 14) ? 1 : 0);
      tick();
      checkOutput("t3_gnt",  32'(bus.gnt),      'h1);
      checkOutput("t3_data", 32'(bus.rnd_data), 32'(seq[k]));
    end
    checkOutput("t3_wrap_pulse", 32'(bus.wrap), 0);
    applyStimulus(2'b00, 1'b0, 4'h0);

    // Zero seed load during STEP aborts and restores SEED
    applyReset();
    applyStimulus(2'b01, 1'b0, 4'h0);
    tick();
    checkOutput("t4_busy_step", 32'(bus.busy), 1);
    applyStimulus(2'b01, 1'b1, 4'h0);
    tick();
    checkOutput("t4_abort_busy", 32'(bus.busy), 0);
    checkOutput("t4_abort_gnt",  32'(bus.gnt),  0);
    checkOutput("t4_abort_wrap", 32'(bus.wrap), 0);
    applyStimulus(2'b01, 1'b0, 4'h0);
    tick();
    tick();
    checkOutput("t4_gnt_early", 32'(bus.gnt), 0);
    tick();
    checkOutput("t4_gnt",  32'(bus.gnt),      'h1);
    checkOutput("t4_data", 32'(bus.rnd_data), 'h2);
    // Seed load in the GRANT cycle beats the grant
    tick();
    tick();
    applyStimulus(2'b01, 1'b1, 4'b1011);
    tick();
    checkOutput("t4_load_gnt",   32'(bus.gnt),       0);
    checkOutput("t4_load_valid", 32'(bus.rnd_valid), 0);
    checkOutput("t4_load_hold",  32'(bus.rnd_data),  'h2);
    applyStimulus(2'b01, 1'b0, 4'h0);
    tick();
    tick();
    tick();
    checkOutput("t4_seed_gnt",  32'(bus.gnt),      'h1);
    checkOutput("t4_seed_data", 32'(bus.rnd_data), 'h7);
    applyStimulus(2'b00, 1'b0, 4'h0);

    // Request dropped during STEP: cancelled, pointer kept, LFSR progress kept
    applyReset();
    applyStimulus(2'b01, 1'b0, 4'h0);
    tick();
    applyStimulus(2'b00, 1'b0, 4'h0);
    tick();
    tick();
    checkOutput("t5_cancel_gnt",   32'(bus.gnt),       0);
    checkOutput("t5_cancel_valid", 32'(bus.rnd_valid), 0);
    applyStimulus(2'b11, 1'b0, 4'h0);
    tick();
    tick();
    tick();
    checkOutput("t5_regnt",  32'(bus.gnt),      'h1);
    checkOutput("t5_redata", 32'(bus.rnd_data), 'h4);
    applyStimulus(2'b00, 1'b0, 4'h0);

    // Asynchronous reset in the middle of STEP
    applyReset();
    applyStimulus(2'b01, 1'b0, 4'h0);
    tick();
    tick();
    tick();
    checkOutput("t6_pre_data", 32'(bus.rnd_data), 'h2);
    tick();
    checkOutput("t6_pre_busy", 32'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_async_busy", 32'(bus.busy),      0);
    checkOutput("t6_async_data", 32'(bus.rnd_data),  0);
    checkOutput("t6_async_gnt",  32'(bus.gnt),       0);
    checkOutput("t6_async_vld",  32'(bus.rnd_valid), 0);
    #1 rst = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("t6_post_gnt",  32'(bus.gnt),      'h1);
    checkOutput("t6_post_data", 32'(bus.rnd_data), 'h2);
    applyStimulus(2'b00, 1'b0, 4'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
